// File: rtl/alu_execute_stage.sv
// ALU execute stage: single-cycle logic/arithmetic ops and bit-serial shifts
// behind a valid/ready handshake on both sides.
module alu_execute_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControlInput,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] alu_val;
  logic             alu_ill;
  logic [WIDTH-1:0] sh_next;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign amt       = op_b[SHW-1:0];
  assign is_shift  = (ALUControlInput == OP_SLL) || (ALUControlInput == OP_SRL) ||
                     (ALUControlInput == OP_SRA);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Single-cycle ALU; shifts here only cover the zero-amount case.
  always_comb begin
    alu_val = '0;
    alu_ill = 1'b0;
    case (ALUControlInput)
      OP_AND:  alu_val = op_a & op_b;
      OP_OR:   alu_val = op_a | op_b;
      OP_ADD:  alu_val = op_a + op_b;
      OP_SUB:  alu_val = op_a - op_b;
      OP_SLT:  alu_val = WIDTH'($signed(op_a) < $signed(op_b));
      OP_NOR:  alu_val = ~(op_a | op_b);
      OP_SLL, OP_SRL, OP_SRA: alu_val = op_a;
      default: alu_ill = 1'b1;
    endcase
  end

  // One bit position per cycle for the operation captured at acceptance.
  always_comb begin
    sh_next = sh_q;
    case (op_q)
      OP_SLL:  sh_next = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, sh_q[WIDTH-1:1]};
      OP_SRA:  sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_next = sh_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = ALUControlInput;
          if (is_shift && (amt != '0)) begin
            sh_d    = op_a;
            cnt_d   = amt;
            state_d = SHIFT;
          end else begin
            result_d  = alu_val;
            zero_d    = (alu_val == '0);
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d  = sh_next;
          zero_d    = (sh_next == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage against an arithmetic reference model.
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControlInput(ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {illegal, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int amt;
    amt = int'(b % 32);
    case (op)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      4'b1100: return {1'b0, ~(a | b)};
      4'b0011: return {1'b0, a << amt};
      4'b0100: return {1'b0, a >> amt};
      4'b0101: return {1'b0, 32'($signed(a) >>> amt)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0011 || op == 4'b0100 || op == 4'b0101) return int'(b % 32) + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [32:0] exp;
    int exp_lat;
    int lat;
    exp     = ref_alu(op, a, b);
    exp_lat = ref_lat(op, b);
    @(negedge clk);
    ctrl = op; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; ctrl = 4'($urandom);
    lat = 1;
    if (exp_lat > 1) check("in_ready_shift", in_ready, 0);
    while (!out_valid && lat < 40) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("out_valid", out_valid, 1);
    check("result", result, exp[31:0]);
    check("zero", zero, exp[31:0] == 32'd0);
    check("illegal", illegal, exp[32]);
    in_valid  = 1'b0;
    out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      op_a = $urandom; op_b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_result", result, exp[31:0]);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(4'b0110, 32'd5, 32'd5, 0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b0101, 32'h8000_0000, 32'd4, 0);
    run_op(4'b0011, 32'h1234_5679, 32'h21, 0);
    run_op(4'b1111, $urandom, $urandom, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 3);
    run_op(4'b0100, 32'hF000_0000, 32'd0, 3);
    run_op(4'b0100, 32'h8000_0001, 32'd31, 1);

    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      run_op(rop, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    // Reset mid-shift aborts the operation.
    @(negedge clk);
    ctrl = 4'b0100; op_a = $urandom | 32'h8000_0000; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_shift_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check("rst_low_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 0);
    check("abort_illegal", illegal, 0);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      check("no_stale", out_valid, 0);
    end
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
